// File: rtl/rr_arb_mux_pkg.sv
// ============================================================================
//  rr_arb_mux_pkg
//  Shared arbitration-mode constants and index-width helper for rr_arb_mux.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package rr_arb_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Smallest w such that 2**w >= v; used to size channel indices.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb_mux_grant.sv
// ============================================================================
//  rr_arb_grant
//  Combinational grant logic: round-robin from a pointer, or lowest index wins.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb_grant
  import rr_arb_mux_pkg::*;
#(
  parameter int M  = 4,
  parameter int SW = 2,
  parameter int RR = ARB_RR
) (
  input  logic [M-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [M-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          any_req
);

  logic found;
  int   cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < M; k++) begin
      // ptr is always < M, so one conditional subtraction wraps the search.
      cand = (RR == ARB_RR) ? int'(ptr) + k : k;
      if (cand >= M) cand = cand - M;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = SW'(cand);
      end
    end
  end

  assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/rr_arb_mux.sv
// ============================================================================
//  rr_arb_mux
//  M-to-1 valid/ready channel mux with round-robin or fixed-priority
//  arbitration and a one-entry registered output stage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int N  = 32,
  parameter int M  = 4,
  parameter int SW = 2,
  parameter int RR = ARB_RR
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [M*N-1:0] IN_DATA,
  input  logic [M-1:0]   IN_VALID,
  output logic [M-1:0]   IN_READY,
  output logic [N-1:0]   OUT_DATA,
  output logic [SW-1:0]  OUT_SEL,
  output logic           OUT_VALID,
  input  logic           OUT_READY
);

  logic [M-1:0]  gnt;
  logic [SW-1:0] gnt_idx;
  logic          any_req;
  logic          load;
  logic          xfer;
  logic [N-1:0]  win_data;

  logic [SW-1:0] ptr_d,       ptr_q;
  logic [N-1:0]  out_data_d,  out_data_q;
  logic [SW-1:0] out_sel_d,   out_sel_q;
  logic          out_valid_d, out_valid_q;

  rr_arb_grant #(
    .M  (M),
    .SW (SW),
    .RR (RR)
  ) u_grant (
    .req     (IN_VALID),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .idx     (gnt_idx),
    .any_req (any_req)
  );

  // The slot may accept a new word when empty or draining this same cycle.
  assign load     = ~out_valid_q | OUT_READY;
  assign xfer     = load & any_req & ~RST;
  assign IN_READY = {M{xfer}} & gnt;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < M; i++) begin
      win_data = win_data | ({N{gnt[i]}} & IN_DATA[i*N +: N]);
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = any_req;
      if (any_req) begin
        out_data_d = win_data;
        out_sel_d  = gnt_idx;
        if (RR == ARB_RR) begin
          ptr_d = (int'(gnt_idx) == M - 1) ? '0 : gnt_idx + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_SEL   = out_sel_q;
  assign OUT_VALID = out_valid_q;

  // Indices >= M exist only when M is not a power of two and must never occur.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (SW == clog2(M));
      assert (int'(ptr_q) < M);
      assert (int'(out_sel_q) < M);
      assert (!any_req || int'(gnt_idx) < M);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
// ============================================================================
//  tb_rr_arb_mux
//  Bench for rr_arb_mux: round-robin M=4, fixed-priority M=4, round-robin M=3.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rr_arb_mux;

  logic clk;
  logic rst;

  logic [127:0] a_d;  logic [3:0] a_v;  logic [3:0] a_ir;
  logic [31:0]  a_od; logic [1:0] a_os; logic a_ov; logic a_or;
  logic [127:0] b_d;  logic [3:0] b_v;  logic [3:0] b_ir;
  logic [31:0]  b_od; logic [1:0] b_os; logic b_ov; logic b_or;
  logic [95:0]  c_d;  logic [2:0] c_v;  logic [2:0] c_ir;
  logic [31:0]  c_od; logic [1:0] c_os; logic c_ov; logic c_or;

  rr_arb_mux #(.N(32), .M(4), .SW(2), .RR(1)) u_a (
    .CLK(clk), .RST(rst), .IN_DATA(a_d), .IN_VALID(a_v), .IN_READY(a_ir),
    .OUT_DATA(a_od), .OUT_SEL(a_os), .OUT_VALID(a_ov), .OUT_READY(a_or));
  rr_arb_mux #(.N(32), .M(4), .SW(2), .RR(0)) u_b (
    .CLK(clk), .RST(rst), .IN_DATA(b_d), .IN_VALID(b_v), .IN_READY(b_ir),
    .OUT_DATA(b_od), .OUT_SEL(b_os), .OUT_VALID(b_ov), .OUT_READY(b_or));
  rr_arb_mux #(.N(32), .M(3), .SW(2), .RR(1)) u_c (
    .CLK(clk), .RST(rst), .IN_DATA(c_d), .IN_VALID(c_v), .IN_READY(c_ir),
    .OUT_DATA(c_od), .OUT_SEL(c_os), .OUT_VALID(c_ov), .OUT_READY(c_or));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-DUT applied inputs and reference state.
  logic [3:0]   cur_v [3];
  logic [127:0] cur_d [3];
  logic         cur_r [3];
  logic         mv [3];
  logic [31:0]  md [3];
  int           ms [3];
  int           mp [3];
  logic [3:0]   last_ir [3];

  typedef struct {
    logic [3:0] v;
    logic       rdy;
    logic [3:0] exp_ir;
    logic       exp_ov;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t         tbl [12];
  logic [31:0]  chd [4];
  logic [127:0] tbl_d;

  function automatic int dm(input int j);
    return (j == 2) ? 3 : 4;
  endfunction

  function automatic int drr(input int j);
    return (j == 1) ? 0 : 1;
  endfunction

  // Winner: first requester in rotation order starting at ptr (or from 0).
  function automatic int pick(input int m, input int rr, input int ptr, input logic [3:0] v);
    for (int k = 0; k < m; k++) begin
      int i;
      i = rr ? (ptr + k) % m : k;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] get_ir(input int j);
    case (j)
      0:       return a_ir;
      1:       return b_ir;
      default: return {1'b0, c_ir};
    endcase
  endfunction

  function automatic logic get_ov(input int j);
    case (j)
      0:       return a_ov;
      1:       return b_ov;
      default: return c_ov;
    endcase
  endfunction

  function automatic logic [31:0] get_od(input int j);
    case (j)
      0:       return a_od;
      1:       return b_od;
      default: return c_od;
    endcase
  endfunction

  function automatic logic [1:0] get_os(input int j);
    case (j)
      0:       return a_os;
      1:       return b_os;
      default: return c_os;
    endcase
  endfunction

  task automatic chk(input string nm, input int j, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: actual=%0h required=%0h", nm, j, act, exp);
    end
  endtask

  task automatic drive_all();
    a_v = cur_v[0]; a_d = cur_d[0];       a_or = cur_r[0];
    b_v = cur_v[1]; b_d = cur_d[1];       b_or = cur_r[1];
    c_v = cur_v[2][2:0]; c_d = cur_d[2][95:0]; c_or = cur_r[2];
  endtask

  // One clock cycle: new inputs for one DUT, all three checked against the model.
  task automatic step(input int id, input logic [3:0] v, input logic [127:0] d, input logic rdy);
    int   w [3];
    logic ld [3];
    cur_v[id] = v; cur_d[id] = d; cur_r[id] = rdy;
    @(negedge clk);
    drive_all();
    #1;
    for (int j = 0; j < 3; j++) begin
      w[j]       = pick(dm(j), drr(j), mp[j], cur_v[j]);
      ld[j]      = !mv[j] || cur_r[j];
      last_ir[j] = get_ir(j);
      chk("in_ready", j, 32'(last_ir[j]), (ld[j] && w[j] >= 0) ? (32'd1 << w[j]) : 32'd0);
    end
    @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      if (ld[j]) begin
        if (w[j] >= 0) begin
          mv[j] = 1'b1;
          md[j] = cur_d[j][w[j]*32 +: 32];
          ms[j] = w[j];
          if (drr(j) == 1) mp[j] = (w[j] + 1) % dm(j);
        end else begin
          mv[j] = 1'b0;
        end
      end
    end
    #1;
    for (int j = 0; j < 3; j++) begin
      chk("out_valid", j, 32'(get_ov(j)), 32'(mv[j]));
      if (mv[j]) begin
        chk("out_data", j, get_od(j), md[j]);
        chk("out_sel", j, 32'(get_os(j)), 32'(ms[j]));
      end
    end
  endtask

  // Asynchronous reset mid-cycle with all channels requesting.
  task automatic do_reset();
    @(negedge clk);
    for (int j = 0; j < 3; j++) cur_v[j] = 4'hF;
    drive_all();
    #2;
    rst = 1'b1;
    #1;
    for (int j = 0; j < 3; j++) begin
      chk("rst_valid", j, 32'(get_ov(j)), 32'd0);
      chk("rst_ready", j, 32'(get_ir(j)), 32'd0);
      chk("rst_data",  j, get_od(j),      32'd0);
      chk("rst_sel",   j, 32'(get_os(j)), 32'd0);
      mv[j] = 1'b0; mp[j] = 0; ms[j] = 0; md[j] = '0;
      cur_v[j] = 4'h0;
    end
    drive_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0]   held_sel;
    logic [31:0]  held_data;
    logic [127:0] rd;

    chd[0] = 32'h0000_AAAA; chd[1] = 32'h3F80_0000;
    chd[2] = 32'h4000_0000; chd[3] = 32'hC0A0_0000;
    tbl_d  = {chd[3], chd[2], chd[1], chd[0]};
    //            v        rdy   exp_ir   ov    sel
    tbl[0]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[2]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[4]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[5]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[6]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[9]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3};
    tbl[10] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd3};
    tbl[11] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};

    for (int j = 0; j < 3; j++) begin
      cur_v[j] = '0; cur_d[j] = '0; cur_r[j] = 1'b1;
      mv[j] = 1'b0; md[j] = '0; ms[j] = 0; mp[j] = 0; last_ir[j] = '0;
    end
    rst = 1'b1;
    drive_all();
    #2;
    chk("init_valid", 0, 32'(a_ov), 32'd0);
    chk("init_sel",   0, 32'(a_os), 32'd0);
    chk("init_data",  0, a_od,      32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven sequence on the round-robin M=4 instance.
    for (int r = 0; r < 12; r++) begin
      step(0, tbl[r].v, tbl_d, tbl[r].rdy);
      chk("tbl_ready", 0, 32'(last_ir[0]), 32'(tbl[r].exp_ir));
      chk("tbl_valid", 0, 32'(a_ov),       32'(tbl[r].exp_ov));
      if (tbl[r].exp_ov) begin
        chk("tbl_sel",  0, 32'(a_os), 32'(tbl[r].exp_sel));
        chk("tbl_data", 0, a_od,      chd[tbl[r].exp_sel]);
      end
    end

    // Fairness: all channels valid, sink always ready.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(0, 4'hF, tbl_d, 1'b1);
      chk("rr_valid", 0, 32'(a_ov), 32'd1);
      chk("rr_sel",   0, 32'(a_os), 32'(i % 4));
    end

    // Reset while holding a word, then a lone ch2 request.
    do_reset();
    step(0, 4'b0100, tbl_d, 1'b1);
    chk("post_rst_sel", 0, 32'(a_os), 32'd2);

    // Backpressure for 5 cycles, then drain and load together.
    step(0, 4'hF, tbl_d, 1'b0);
    held_sel  = a_os;
    held_data = a_od;
    for (int i = 0; i < 5; i++) begin
      step(0, 4'hF, tbl_d, 1'b0);
      chk("bp_ready", 0, 32'(last_ir[0]), 32'd0);
      chk("bp_sel",   0, 32'(a_os),       32'(held_sel));
      chk("bp_data",  0, a_od,            held_data);
    end
    step(0, 4'hF, tbl_d, 1'b1);
    chk("bp_drain_ready", 0, 32'(last_ir[0]), 32'b1000);
    chk("bp_drain_sel",   0, 32'(a_os),       32'd3);

    // Fixed priority: ch3 starved while a lower index requests.
    do_reset();
    step(1, 4'b1100, tbl_d, 1'b1);
    chk("fp_sel_a", 1, 32'(b_os), 32'd2);
    step(1, 4'b1110, tbl_d, 1'b1);
    chk("fp_sel_b", 1, 32'(b_os), 32'd1);
    step(1, 4'b1110, tbl_d, 1'b1);
    chk("fp_sel_c", 1, 32'(b_os), 32'd1);
    chk("fp_ready", 1, 32'(last_ir[1]), 32'b0010);

    // Non-power-of-two channel count.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(2, 4'b0111, tbl_d, 1'b1);
      chk("m3_sel", 2, 32'(c_os), 32'(i % 3));
    end

    // Random traffic on every instance against the reference model.
    do_reset();
    for (int i = 0; i < 900; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      step(i % 3, 4'($urandom), rd, ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
